// File: rtl/stream_max.sv
// stream_max: serial max/argmax reducer over a valid/ready element stream
module stream_max #(
    parameter int DATA_WIDTH  = 16,
    parameter int DATA_LENGTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_max,
    output logic [(DATA_LENGTH > 1 ? $clog2(DATA_LENGTH) : 1)-1:0] out_idx
);
    localparam int IDX_WIDTH = DATA_LENGTH > 1 ? $clog2(DATA_LENGTH) : 1;
    localparam logic ACCUM = 1'b0;
    localparam logic HOLD  = 1'b1;
    localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(DATA_LENGTH - 1);
    logic                 state;
    logic [IDX_WIDTH-1:0] cnt;
    logic                 in_fire;
    logic                 last;
    assign in_ready  = rst_n && state == ACCUM;
    assign out_valid = state == HOLD;
    assign in_fire   = in_valid && in_ready;
    assign last      = cnt == LAST;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ACCUM;
            cnt     <= '0;
            out_max <= '0;
            out_idx <= '0;
        end else if (in_fire) begin
            if (cnt == '0 || in_data > out_max) begin
                out_max <= in_data;
                out_idx <= cnt;
            end
            cnt   <= last ? '0 : cnt + IDX_WIDTH'(1);
            state <= last ? HOLD : ACCUM;
        end else if (state == HOLD && out_ready) begin
            state <= ACCUM;
        end
    end
endmodule
